// File: rtl/cpu_pkg.sv
// Shared CPU constants and the store-buffer entry type.
// Used by the data memory, pipeline registers and store buffer.
package cpu_pkg;
   localparam int WORD_W    = 32;
   localparam int ADDR_W    = 32;
   localparam int MEM_IDX_W = 10;
   localparam int SB_DEPTH  = 4;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [WORD_W-1:0] data;
   } sb_entry_t;
endpackage

// File: rtl/store_buffer_if.sv
// Pipeline-side store/load port of the store buffer.
// master = memory stage, slave = store buffer.
interface store_buffer_if
   import cpu_pkg::*;
   ;
   logic              st_valid;
   logic [ADDR_W-1:0] st_addr;
   logic [WORD_W-1:0] st_data;
   logic              st_ready;
   logic              ld_valid;
   logic [ADDR_W-1:0] ld_addr;
   logic [WORD_W-1:0] ld_data;
   logic              ld_hit;

   modport master (
      output st_valid, st_addr, st_data,
      output ld_valid, ld_addr,
      input  st_ready, ld_data, ld_hit
   );

   modport slave (
      input  st_valid, st_addr, st_data,
      input  ld_valid, ld_addr,
      output st_ready, ld_data, ld_hit
   );
endinterface

// File: rtl/sb_fwd_match.sv
// DEPTH-way word-index compare with youngest-first select.
// Scans oldest to youngest so the last match wins.
module sb_fwd_match
   import cpu_pkg::*;
#(
   parameter  int DEPTH = SB_DEPTH,
   parameter  int IDX_W = MEM_IDX_W,
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0]  valid,
   input  logic [IDX_W-1:0]  ent_idx  [DEPTH],
   input  logic [WORD_W-1:0] ent_data [DEPTH],
   input  logic [PW-1:0]     tail,
   input  logic [IDX_W-1:0]  key,
   output logic              hit,
   output logic [WORD_W-1:0] data
);
   logic [PW-1:0] idx;

   always_comb begin
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      for (int k = DEPTH; k >= 1; k--) begin
         idx = tail - PW'(k);
         if (valid[idx] && ent_idx[idx] == key) begin
            hit  = 1'b1;
            data = ent_data[idx];
         end
      end
   end
endmodule

// File: rtl/store_buffer.sv
// Memory-stage store buffer: in-order drain to data memory,
// youngest-match forwarding to loads.
module store_buffer
   import cpu_pkg::*;
#(
   parameter  int DEPTH = SB_DEPTH,
   parameter  int IDX_W = MEM_IDX_W,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   store_buffer_if.slave     cpu,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [WORD_W-1:0] mem_rdata,
   output logic              empty
);
   sb_entry_t        ents_q [DEPTH];
   sb_entry_t        ents_d [DEPTH];
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;

   logic [IDX_W-1:0]  ent_idx  [DEPTH];
   logic [WORD_W-1:0] ent_data [DEPTH];
   logic              f_hit;
   logic [WORD_W-1:0] f_data;
   logic              push;
   logic              drain;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ent_idx[i]  = ents_q[i].addr[IDX_W-1:0];
         ent_data[i] = ents_q[i].data;
      end
   end

   sb_fwd_match #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_fwd (
      .valid    (valid_q),
      .ent_idx  (ent_idx),
      .ent_data (ent_data),
      .tail     (tail_q),
      .key      (cpu.ld_addr[IDX_W-1:0]),
      .hit      (f_hit),
      .data     (f_data)
   );

   assign empty        = (count_q == '0);
   assign cpu.st_ready = (count_q != CW'(DEPTH));
   assign cpu.ld_hit   = cpu.ld_valid && f_hit;
   assign cpu.ld_data  = cpu.ld_hit ? f_data : mem_rdata;
   assign push         = cpu.st_valid && cpu.st_ready;

   // A load miss needs the shared address port; a hit does not.
   assign drain     = !empty && !(cpu.ld_valid && !cpu.ld_hit);
   assign mem_we    = drain;
   assign mem_addr  = drain ? ents_q[head_q].addr : cpu.ld_addr;
   assign mem_wdata = ents_q[head_q].data;

   always_comb begin
      ents_d  = ents_q;
      valid_d = valid_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (drain) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + PW'(1);
      end
      if (push) begin
         ents_d[tail_q].addr = cpu.st_addr;
         ents_d[tail_q].data = cpu.st_data;
         valid_d[tail_q]     = 1'b1;
         tail_d              = tail_q + PW'(1);
      end
      if (push && !drain)
         count_d = count_q + CW'(1);
      else if (!push && drain)
         count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         valid_q <= valid_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      ents_q <= ents_d;
   end
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue-based reference model,
// directed scenarios and randomized load/store traffic.
module tb_store_buffer;
   import cpu_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   store_buffer_if sbi ();

   logic [ADDR_W-1:0] mem_addr;
   logic [WORD_W-1:0] mem_wdata;
   logic              mem_we;
   logic [WORD_W-1:0] mem_rdata;
   logic              empty;

   store_buffer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cpu       (sbi),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata),
      .empty     (empty)
   );

   // Data memory attached to the DUT: sync write, async read.
   logic [31:0] dut_mem [1024] = '{default: 32'h0};
   assign mem_rdata = dut_mem[mem_addr[9:0]];
   always @(posedge clk) begin
      if (mem_we) dut_mem[mem_addr[9:0]] <= mem_wdata;
   end

   // Reference model: pending stores in program order + memory image.
   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } ent_t;
   ent_t        q[$];
   logic [31:0] ref_mem [1024] = '{default: 32'h0};

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            q.delete();
            chk("rst_st_ready", {31'b0, sbi.st_ready}, 32'd1);
            chk("rst_empty", {31'b0, empty}, 32'd1);
            chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
            chk("rst_ld_hit", {31'b0, sbi.ld_hit}, 32'd0);
         end else begin
            bit          e_hit, e_we, e_push;
            logic [31:0] e_fwd;
            int          sz;
            e_hit = 1'b0;
            e_fwd = 32'h0;
            sz    = q.size();
            for (int i = sz - 1; i >= 0; i--) begin
               if (!e_hit && q[i].a[9:0] == sbi.ld_addr[9:0]) begin
                  e_hit = 1'b1;
                  e_fwd = q[i].d;
               end
            end
            e_hit  = e_hit && sbi.ld_valid;
            e_we   = (sz != 0) && !(sbi.ld_valid && !e_hit);
            e_push = sbi.st_valid && (sz < 4);
            chk("st_ready", {31'b0, sbi.st_ready}, {31'b0, sz < 4});
            chk("empty", {31'b0, empty}, {31'b0, sz == 0});
            chk("mem_we", {31'b0, mem_we}, {31'b0, e_we});
            chk("mem_addr", mem_addr, e_we ? q[0].a : sbi.ld_addr);
            if (e_we) chk("mem_wdata", mem_wdata, q[0].d);
            if (sbi.ld_valid) begin
               chk("ld_hit", {31'b0, sbi.ld_hit}, {31'b0, e_hit});
               chk("ld_data", sbi.ld_data,
                   e_hit ? e_fwd : ref_mem[sbi.ld_addr[9:0]]);
            end
            if (e_we) begin
               ref_mem[q[0].a[9:0]] = q[0].d;
               void'(q.pop_front());
            end
            if (e_push) q.push_back('{a: sbi.st_addr, d: sbi.st_data});
         end
      end
   end

   task automatic set_in(input bit sv, input logic [31:0] sa,
                         input logic [31:0] sd, input bit lv,
                         input logic [31:0] la);
      sbi.st_valid = sv;
      sbi.st_addr  = sa;
      sbi.st_data  = sd;
      sbi.ld_valid = lv;
      sbi.ld_addr  = la;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int diff;
      set_in(0, 0, 0, 0, 0);
      repeat (3) tick();
      rst_n = 1'b1;

      // Idle after reset, then a miss load reaches the port.
      repeat (10) tick();
      set_in(0, 0, 0, 1, 32'h8);
      @(negedge clk);
      chk("idle_mem_addr", mem_addr, 32'h8);
      chk("idle_ld_hit", {31'b0, sbi.ld_hit}, 32'd0);
      tick();

      // Single store drains the following cycle.
      set_in(1, 32'h4, 32'hDEAD, 0, 0);
      tick();
      set_in(0, 0, 0, 0, 0);
      @(negedge clk);
      chk("drain1_we", {31'b0, mem_we}, 32'd1);
      chk("drain1_addr", mem_addr, 32'h4);
      chk("drain1_wdata", mem_wdata, 32'hDEAD);
      tick();
      chk("drain1_empty", {31'b0, empty}, 32'd1);
      set_in(0, 0, 0, 1, 32'h4);
      @(negedge clk);
      chk("read_back", sbi.ld_data, 32'hDEAD);
      tick();

      // Fill while a load miss holds the port, then drain in order.
      for (int i = 0; i < 4; i++) begin
         set_in(1, 32'h20 + 4 * i, 32'hA0 + i, 1, 32'h100);
         tick();
      end
      set_in(0, 0, 0, 1, 32'h100);
      @(negedge clk);
      chk("full_ready", {31'b0, sbi.st_ready}, 32'd0);
      chk("full_we", {31'b0, mem_we}, 32'd0);
      tick();
      for (int i = 0; i < 4; i++) begin
         set_in(0, 0, 0, 0, 0);
         @(negedge clk);
         chk("order_addr", mem_addr, 32'h20 + 4 * i);
         chk("order_we", {31'b0, mem_we}, 32'd1);
         tick();
      end

      // Youngest match wins; index-only compare.
      set_in(1, 32'h10, 32'h1, 1, 32'h200);
      tick();
      set_in(1, 32'h10, 32'h2, 1, 32'h200);
      tick();
      set_in(0, 0, 0, 1, 32'h10);
      @(negedge clk);
      chk("fwd_hit", {31'b0, sbi.ld_hit}, 32'd1);
      chk("fwd_data", sbi.ld_data, 32'h2);
      tick();
      set_in(0, 0, 0, 1, 32'h410);
      @(negedge clk);
      chk("alias_hit", {31'b0, sbi.ld_hit}, 32'd1);
      chk("alias_data", sbi.ld_data, 32'h2);
      tick();
      set_in(0, 0, 0, 0, 0);
      repeat (3) tick();

      // Full buffer: hit + push in one cycle -> drain, push refused.
      for (int i = 0; i < 4; i++) begin
         set_in(1, 32'h30 + 4 * i, 32'hC0 + i, 1, 32'h300);
         tick();
      end
      set_in(1, 32'h40, 32'h55, 1, 32'h30);
      @(negedge clk);
      chk("simul_ready", {31'b0, sbi.st_ready}, 32'd0);
      chk("simul_we", {31'b0, mem_we}, 32'd1);
      chk("simul_hit", {31'b0, sbi.ld_hit}, 32'd1);
      tick();
      set_in(1, 32'h40, 32'h55, 0, 0);
      @(negedge clk);
      chk("simul_ready2", {31'b0, sbi.st_ready}, 32'd1);
      tick();
      set_in(0, 0, 0, 0, 0);
      repeat (6) tick();
      chk("simul_mem40", dut_mem[10'h40], 32'h55);

      // Async reset in the middle of a drain.
      for (int i = 0; i < 3; i++) begin
         set_in(1, 32'h50 + 4 * i, 32'h71 + i, 1, 32'h300);
         tick();
      end
      set_in(0, 0, 0, 0, 0);
      @(negedge clk);
      chk("rd_we_first", {31'b0, mem_we}, 32'd1);
      chk("rd_addr_first", mem_addr, 32'h50);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rd_we_async", {31'b0, mem_we}, 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("rd_empty", {31'b0, empty}, 32'd1);
      chk("rd_mem50", dut_mem[10'h50], 32'h71);
      chk("rd_mem54", dut_mem[10'h54], 32'h0);
      chk("rd_mem58", dut_mem[10'h58], 32'h0);
      tick();

      // Randomized traffic over a small aliased address pool.
      for (int c = 0; c < 3000; c++) begin
         bit          sv, lv;
         logic [31:0] sa, la;
         sv = (q.size() < 4) && ($urandom_range(0, 2) != 0);
         lv = ($urandom_range(0, 2) == 0);
         sa = (32'($urandom_range(0, 3)) << 10)
            + 32'h80 + 4 * 32'($urandom_range(0, 7));
         la = (32'($urandom_range(0, 3)) << 10)
            + 32'h80 + 4 * 32'($urandom_range(0, 7));
         set_in(sv, sa, $urandom, lv, la);
         tick();
      end
      set_in(0, 0, 0, 0, 0);
      repeat (8) tick();

      diff = 0;
      for (int i = 0; i < 1024; i++) begin
         if (dut_mem[i] !== ref_mem[i]) diff++;
      end
      chk("mem_image", 32'(diff), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end
endmodule
